// File: rtl/avst_demultiplexer.sv
// 1-to-2 Avalon-ST packet demultiplexer: whole packets are steered by the channel on their sop beat
// into one of two 2-entry output buffers; malformed traffic is counted in a saturating drop counter.
module avst_demultiplexer #(
  parameter int unsigned data_width    = 128,
  parameter int unsigned empty_width   = 4,
  parameter int unsigned channel_width = 10,
  parameter int unsigned split_channel = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [empty_width-1:0]   avsi_empty,
  output logic                     avsi_ready,
  output logic [channel_width-1:0] avso_one_channel,
  output logic [data_width-1:0]    avso_one_data,
  output logic                     avso_one_sop,
  output logic                     avso_one_eop,
  output logic [empty_width-1:0]   avso_one_empty,
  output logic                     avso_one_valid,
  input  logic                     avso_one_ready,
  output logic [channel_width-1:0] avso_two_channel,
  output logic [data_width-1:0]    avso_two_data,
  output logic                     avso_two_sop,
  output logic                     avso_two_eop,
  output logic [empty_width-1:0]   avso_two_empty,
  output logic                     avso_two_valid,
  input  logic                     avso_two_ready,
  output logic [15:0]              drop_count
);

  typedef struct packed {
    logic [channel_width-1:0] channel;
    logic [data_width-1:0]    data;
    logic                     sop;
    logic                     eop;
    logic [empty_width-1:0]   empty;
  } beat_t;

  typedef enum logic [1:0] {IDLE, PKT_ONE, PKT_TWO} state_t;

  localparam logic [channel_width:0] SPLIT = (channel_width + 1)'(split_channel);

  state_t      state_q, state_d;
  beat_t       in_beat;
  beat_t       head [2];
  logic [1:0]  push, pop, full, out_ready, out_valid;
  logic        accept, to_one, drop_inc;
  logic [15:0] drop_q, drop_d;

  assign in_beat    = {avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty};
  assign out_ready  = {avso_two_ready, avso_one_ready};
  assign avsi_ready = !full[0] && !full[1];
  assign accept     = avsi_valid && avsi_ready;
  assign to_one     = {1'b0, avsi_channel} < SPLIT;

  always_comb begin
    state_d  = state_q;
    push     = '0;
    drop_inc = 1'b0;
    if (accept) begin
      if (avsi_sop) begin
        // A sop arriving mid-packet truncates the old packet; the new one still routes normally.
        drop_inc = (state_q != IDLE);
        if (to_one) begin
          push[0] = 1'b1;
          state_d = avsi_eop ? IDLE : PKT_ONE;
        end else begin
          push[1] = 1'b1;
          state_d = avsi_eop ? IDLE : PKT_TWO;
        end
      end else begin
        unique case (state_q)
          PKT_ONE: begin
            push[0] = 1'b1;
            if (avsi_eop) state_d = IDLE;
          end
          PKT_TWO: begin
            push[1] = 1'b1;
            if (avsi_eop) state_d = IDLE;
          end
          default: drop_inc = 1'b1;
        endcase
      end
    end
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    beat_t      mem_q [2];
    logic [1:0] cnt_q;
    logic       wr_q, rd_q;

    assign full[g]      = (cnt_q == 2'd2);
    assign out_valid[g] = (cnt_q != 2'd0);
    assign pop[g]       = out_valid[g] && out_ready[g];
    assign head[g]      = mem_q[rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem_q <= '{default: '0};
        cnt_q <= '0;
        wr_q  <= 1'b0;
        rd_q  <= 1'b0;
      end else begin
        if (push[g]) begin
          mem_q[wr_q] <= in_beat;
          wr_q        <= ~wr_q;
        end
        if (pop[g]) rd_q <= ~rd_q;
        if (push[g] && !pop[g])      cnt_q <= cnt_q + 2'd1;
        else if (!push[g] && pop[g]) cnt_q <= cnt_q - 2'd1;
      end
    end
  end

  assign {avso_one_channel, avso_one_data, avso_one_sop, avso_one_eop, avso_one_empty} = head[0];
  assign {avso_two_channel, avso_two_data, avso_two_sop, avso_two_eop, avso_two_empty} = head[1];
  assign avso_one_valid = out_valid[0];
  assign avso_two_valid = out_valid[1];
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_avst_demultiplexer.sv
// Bench for avst_demultiplexer: directed vector table and corner sequences, plus random traffic
// scored against a queue-based model of the routing and buffering rules.
module tb_avst_demultiplexer;
  localparam int DW = 128;
  localparam int EW = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] avsi_channel;
  logic [DW-1:0] avsi_data;
  logic          avsi_valid, avsi_sop, avsi_eop, avsi_ready;
  logic [EW-1:0] avsi_empty;
  logic [CW-1:0] avso_one_channel, avso_two_channel;
  logic [DW-1:0] avso_one_data, avso_two_data;
  logic          avso_one_sop, avso_one_eop, avso_one_valid, avso_one_ready;
  logic          avso_two_sop, avso_two_eop, avso_two_valid, avso_two_ready;
  logic [EW-1:0] avso_one_empty, avso_two_empty;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  avst_demultiplexer #(.data_width(DW), .empty_width(EW), .channel_width(CW), .split_channel(512)) dut (
    .clk(clk), .reset_n(reset_n),
    .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_valid(avsi_valid),
    .avsi_sop(avsi_sop), .avsi_eop(avsi_eop), .avsi_empty(avsi_empty), .avsi_ready(avsi_ready),
    .avso_one_channel(avso_one_channel), .avso_one_data(avso_one_data), .avso_one_sop(avso_one_sop),
    .avso_one_eop(avso_one_eop), .avso_one_empty(avso_one_empty), .avso_one_valid(avso_one_valid),
    .avso_one_ready(avso_one_ready),
    .avso_two_channel(avso_two_channel), .avso_two_data(avso_two_data), .avso_two_sop(avso_two_sop),
    .avso_two_eop(avso_two_eop), .avso_two_empty(avso_two_empty), .avso_two_valid(avso_two_valid),
    .avso_two_ready(avso_two_ready),
    .drop_count(drop_count)
  );

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queues hold exactly the beats accepted but not yet delivered.
  beat_t q1[$], q2[$];
  int    cur_dest = 0;
  int    drops = 0;
  bit    m_ready, m_acc;
  beat_t m_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1.delete();
      q2.delete();
      cur_dest = 0;
      drops = 0;
    end else begin
      m_ready = (q1.size() < 2) && (q2.size() < 2);
      m_acc   = avsi_valid && m_ready;
      if (q1.size() != 0 && avso_one_ready) void'(q1.pop_front());
      if (q2.size() != 0 && avso_two_ready) void'(q2.pop_front());
      if (m_acc) begin
        m_b = {avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty};
        if (avsi_sop) begin
          if (cur_dest != 0) drops++;
          cur_dest = (int'(avsi_channel) < 512) ? 1 : 2;
        end else if (cur_dest == 0) begin
          drops++;
        end
        if (cur_dest == 1) q1.push_back(m_b);
        else if (cur_dest == 2) q2.push_back(m_b);
        if (avsi_eop) cur_dest = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("mon_ready", avsi_ready, (q1.size() < 2) && (q2.size() < 2));
      chk("mon_one_valid", avso_one_valid, q1.size() != 0);
      chk("mon_two_valid", avso_two_valid, q2.size() != 0);
      chk("mon_drop_count", drop_count, (drops > 65535) ? 65535 : drops);
      if (q1.size() != 0 && avso_one_valid)
        chk("mon_one_head", {avso_one_channel, avso_one_data, avso_one_sop, avso_one_eop, avso_one_empty}, q1[0]);
      if (q2.size() != 0 && avso_two_valid)
        chk("mon_two_head", {avso_two_channel, avso_two_data, avso_two_sop, avso_two_eop, avso_two_empty}, q2[0]);
    end
  end

  task automatic drive(input logic v, input logic [CW-1:0] ch, input logic s, input logic e,
                       input logic [DW-1:0] d, input logic [EW-1:0] em);
    avsi_valid = v; avsi_channel = ch; avsi_sop = s; avsi_eop = e; avsi_data = d; avsi_empty = em;
  endtask

  // Holds the beat until accepted; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [CW-1:0] ch, input logic s, input logic e,
                           input logic [DW-1:0] d, input logic [EW-1:0] em);
    bit acc = 0;
    drive(1'b1, ch, s, e, d, em);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (avsi_ready) begin acc = 1; break; end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready=0 for 200 cycles expected acceptance");
    end else begin
      @(posedge clk); #1;
    end
    avsi_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [CW-1:0] ch;
    logic          sop;
    logic          eop;
    int            exp_out;
    int            exp_drop;
  } vec_t;

  vec_t vecs[13];
  logic [DW-1:0] d;

  initial begin
    vecs[0]  = '{10'd3,    1'b1, 1'b1, 1, 0};
    vecs[1]  = '{10'd700,  1'b1, 1'b1, 2, 0};
    vecs[2]  = '{10'd511,  1'b1, 1'b1, 1, 0};
    vecs[3]  = '{10'd512,  1'b1, 1'b1, 2, 0};
    vecs[4]  = '{10'd0,    1'b1, 1'b1, 1, 0};
    vecs[5]  = '{10'd1023, 1'b1, 1'b1, 2, 0};
    vecs[6]  = '{10'd5,    1'b0, 1'b0, 0, 1};
    vecs[7]  = '{10'd600,  1'b0, 1'b1, 0, 2};
    vecs[8]  = '{10'd100,  1'b1, 1'b0, 1, 2};
    vecs[9]  = '{10'd100,  1'b0, 1'b1, 1, 2};
    vecs[10] = '{10'd800,  1'b1, 1'b0, 2, 2};
    vecs[11] = '{10'd9,    1'b1, 1'b1, 1, 3};
    vecs[12] = '{10'd9,    1'b0, 1'b1, 0, 4};

    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    avso_one_ready = 1'b1;
    avso_two_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_one_valid", avso_one_valid, 1'b0);
    chk("rst_two_valid", avso_two_valid, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    reset_n = 1'b1;
    #1 chk("rst_ready", avsi_ready, 1'b1);

    // Back-to-back table vectors, both sinks ready
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      d = {4{32'(i) * 32'h0101_1111 + 32'h55}};
      drive(1'b1, vecs[i].ch, vecs[i].sop, vecs[i].eop, d, EW'(i));
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), avsi_ready, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_one_valid", i), avso_one_valid, vecs[i].exp_out == 1);
      chk($sformatf("vec%0d_two_valid", i), avso_two_valid, vecs[i].exp_out == 2);
      if (vecs[i].exp_out == 1) begin
        chk($sformatf("vec%0d_one_ch", i), avso_one_channel, vecs[i].ch);
        chk($sformatf("vec%0d_one_data", i), avso_one_data, d);
        chk($sformatf("vec%0d_one_sopeop", i), {avso_one_sop, avso_one_eop}, {vecs[i].sop, vecs[i].eop});
      end
      if (vecs[i].exp_out == 2) begin
        chk($sformatf("vec%0d_two_ch", i), avso_two_channel, vecs[i].ch);
        chk($sformatf("vec%0d_two_data", i), avso_two_data, d);
      end
      chk($sformatf("vec%0d_drop", i), drop_count, 16'(vecs[i].exp_drop));
    end
    avsi_valid = 1'b0;

    // 4-beat packet on channel 3 with empty on the eop beat
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      d = {4{32'hC0DE_0000 + 32'(k)}};
      drive(1'b1, 10'd3, k == 0, k == 3, d, (k == 3) ? 4'hA : 4'h0);
      @(posedge clk); #1;
      chk($sformatf("pkt4_b%0d_valid", k), avso_one_valid, 1'b1);
      chk($sformatf("pkt4_b%0d_fields", k), {avso_one_sop, avso_one_eop, avso_one_empty, avso_one_data},
          {k == 0, k == 3, (k == 3) ? 4'hA : 4'h0, d});
      chk($sformatf("pkt4_b%0d_two_valid", k), avso_two_valid, 1'b0);
    end
    avsi_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Back-pressure on output two while streaming a 5-beat channel-600 packet
    avso_two_ready = 1'b0;
    send_beat(10'd600, 1'b1, 1'b0, {4{32'hB0}}, 4'h0);
    send_beat(10'd600, 1'b0, 1'b0, {4{32'hB1}}, 4'h0);
    chk("bp_ready_low", avsi_ready, 1'b0);
    drive(1'b1, 10'd600, 1'b0, 1'b0, {4{32'hB2}}, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_ready", k), avsi_ready, 1'b0);
      chk($sformatf("bp_stall%0d_head", k), avso_two_data, {4{32'hB0}});
    end
    avso_two_ready = 1'b1;
    send_beat(10'd600, 1'b0, 1'b0, {4{32'hB2}}, 4'h0);
    send_beat(10'd600, 1'b0, 1'b0, {4{32'hB3}}, 4'h0);
    send_beat(10'd600, 1'b0, 1'b1, {4{32'hB4}}, 4'h3);
    repeat (5) @(posedge clk); #1;
    chk("bp_drained", avso_two_valid, 1'b0);

    // Reset with both buffers occupied, then a fresh packet
    avso_one_ready = 1'b0;
    avso_two_ready = 1'b0;
    send_beat(10'd3, 1'b1, 1'b1, {4{32'hD1}}, 4'h0);
    send_beat(10'd700, 1'b1, 1'b0, {4{32'hD2}}, 4'h0);
    chk("mid_pre_valids", {avso_one_valid, avso_two_valid}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valids", {avso_one_valid, avso_two_valid}, 2'b00);
    chk("mid_rst_drop", drop_count, 16'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    avso_one_ready = 1'b1;
    avso_two_ready = 1'b1;
    send_beat(10'd700, 1'b1, 1'b1, {4{32'hE1}}, 4'h0);
    chk("post_rst_route", {avso_one_valid, avso_two_valid, avso_two_channel}, {1'b0, 1'b1, 10'd700});

    // Saturation: 65535 orphan beats reach the ceiling, one more must not wrap
    @(posedge clk); #1;
    drive(1'b1, 10'd1, 1'b0, 1'b0, '0, '0);
    repeat (65535) @(posedge clk);
    #1 chk("sat_reach", drop_count, 16'hFFFF);
    @(posedge clk);
    #1 chk("sat_hold", drop_count, 16'hFFFF);
    avsi_valid = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3) != 0, CW'($urandom_range(0, 1023)), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3, {$urandom, $urandom, $urandom, $urandom}, EW'($urandom));
      avso_one_ready = $urandom_range(0, 9) < 7;
      avso_two_ready = $urandom_range(0, 9) < 7;
    end
    @(posedge clk); #1;
    avsi_valid = 1'b0;
    avso_one_ready = 1'b1;
    avso_two_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("rand_drained", {avso_one_valid, avso_two_valid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avst_demultiplexer.md
Name: avst_demultiplexer

Overview:
- 1-to-2 Avalon-ST demultiplexer; the receive-side counterpart of the 2-to-1 channel multiplexer.
- Takes one channelised Avalon-ST stream and steers whole packets to output "one" or output "two" by the channel field sampled on the start-of-packet (sop) beat.
- Each output has a 2-entry buffer, so one output back-pressuring stalls the input without losing beats.
- Sits downstream of the multiplexer / link, feeding per-channel consumers.

Parameters:
- data_width, 128, data bus width in bits.
- empty_width, 4, empty field width; equals $clog2(data_width/8).
- channel_width, 10, channel field width.
- split_channel, 512, packets with channel < split_channel go to output one; all others go to output two.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avsi_channel  in  channel_width  input channel.
- avsi_data  in  data_width  input data.
- avsi_valid  in  1  input beat valid.
- avsi_sop  in  1  input start of packet.
- avsi_eop  in  1  input end of packet.
- avsi_empty  in  empty_width  unused bytes on the eop beat.
- avsi_ready  out  1  input accept.
- avso_one_channel/_data/_sop/_eop/_empty  out  as input  output-one beat fields.
- avso_one_valid  out  1  output-one beat valid.
- avso_one_ready  in  1  output-one sink ready.
- avso_two_channel/_data/_sop/_eop/_empty/_valid  out  as output one  output-two beat fields.
- avso_two_ready  in  1  output-two sink ready.
- drop_count  out  16  saturating count of malformed beats/packets.

Behaviour:
- Ready latency is 0. A beat transfers when valid && ready are both high in the same cycle.
- avsi_ready = !full_one && !full_two. It is a function of buffer occupancy registers only and never depends on avsi_valid.
- Routing FSM:
  - States: IDLE, PKT_ONE, PKT_TWO. Reset state is IDLE.
  - Accepted sop beat in any state: destination = (avsi_channel < split_channel) ? one : two.
  - On that sop beat, the beat is pushed to the chosen buffer and the state moves to PKT_ONE or PKT_TWO.
  - If the sop beat also has eop (single-beat packet), the beat is pushed and the state goes to IDLE.
  - Accepted non-sop beat in PKT_x: pushed to buffer x. If eop, go to IDLE; otherwise stay.
  - Accepted non-sop beat in IDLE (orphan beat): accepted and discarded, drop_count += 1, state stays IDLE.
  - Accepted sop beat in PKT_x (truncated packet): drop_count += 1. The previous packet is left unterminated downstream. The new packet is routed normally by its own channel.
- drop_count saturates at 16'hFFFF and does not wrap.
- Output buffers:
  - One 2-entry FIFO per output, each entry {channel, data, sop, eop, empty}. Output fields are driven from the head entry.
  - avso_x_valid = (count_x != 0).
  - Pop occurs when avso_x_valid && avso_x_ready.
  - Push and pop in the same cycle leave the count unchanged, so full throughput is sustained at count 1.
  - Latency: a beat accepted in cycle N appears on its output in cycle N+1.
  - When count_x reaches 2, avsi_ready drops in the following cycle. The registered full flag prevents any overflow.
  - Output fields are held stable while avso_x_valid=1 and avso_x_ready=0.
- Back-pressure on either output stalls the input for both. This is an accepted head-of-line blocking cost.
- Beat payload (channel, data, empty, sop, eop) is passed through unmodified.
- Reset (asynchronous assert, synchronous-safe deassert at a clock edge):
  - FSM goes to IDLE, both counts to 0, drop_count to 0.
  - avso_one_valid and avso_two_valid go to 0. avsi_ready reads 1 as soon as reset_n is high.
  - Data-path registers reset to 0.
  - Reset mid-packet discards buffered beats; the next packet must start with sop.

Test Plan:
- Single 4-beat packet, channel=3, both readies=1 -> 4 beats on output one in cycles N+1..N+4, sop on beat 1, eop on beat 4, empty passed through; avso_two_valid stays 0.
- Alternating 1-beat packets, channel=3 then channel=700, back to back -> each appears on the correct output one cycle after acceptance; avsi_ready constantly 1.
- avso_two_ready=0 while streaming a 5-beat channel=600 packet -> buffer two fills to 2, avsi_ready=0 from the next cycle, no beat lost or duplicated. Release ready -> remaining beats delivered in order.
- Non-sop beat in IDLE, then a sop beat mid-packet -> drop_count = 1 then 2; orphan beat absent from both outputs; new packet routed by its own channel.
- Assert reset_n=0 mid-packet with both buffers holding data -> both valids 0 and drop_count 0 immediately; after release a fresh sop packet routes correctly.
- Force drop_count near saturation with 65536 orphan beats -> holds at 16'hFFFF.
